// File: rtl/riscv_lsu_pkg.sv
// Shared encodings and helpers for the load/store memory interface.
package riscv_lsu_pkg;

  localparam logic [1:0] WHB_BYTE    = 2'b00;
  localparam logic [1:0] WHB_HALF    = 2'b01;
  localparam logic [1:0] WHB_WORD    = 2'b10;
  localparam logic [1:0] WHB_ILLEGAL = 2'b11;

  localparam logic RW_LOAD  = 1'b1;
  localparam logic RW_STORE = 1'b0;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } lsu_state_e;

  // Illegal size counts as misaligned so both take the same error path.
  function automatic logic lsu_misaligned(logic [1:0] size, logic [1:0] off);
    return (size == WHB_ILLEGAL) ||
           ((size == WHB_HALF) && off[0]) ||
           ((size == WHB_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: byte enables and replicated store data out, extended load data in.
module lsu_lane_align
  import riscv_lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        su_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted     = mem_rdata_i >> {offset_i, 3'b000};
    be_o        = 4'b0000;
    wdata_rep_o = '0;
    load_data_o = '0;
    case (size_i)
      WHB_BYTE: begin
        be_o        = 4'b0001 << offset_i;
        wdata_rep_o = {4{wdata_i[7:0]}};
        load_data_o = {{24{su_i & shifted[7]}}, shifted[7:0]};
      end
      WHB_HALF: begin
        be_o        = offset_i[1] ? 4'b1100 : 4'b0011;
        wdata_rep_o = {2{wdata_i[15:0]}};
        load_data_o = {{16{su_i & shifted[15]}}, shifted[15:0]};
      end
      WHB_WORD: begin
        be_o        = 4'b1111;
        wdata_rep_o = wdata_i;
        load_data_o = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Request/acknowledge load/store unit for the unpipelined core; busy stalls the PC.
module lsu_mem_if
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rw,
  input  logic [1:0]  whb,
  input  logic        su,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  lsu_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            rw_q;
  logic            su_q;
  logic [1:0]      whb_q;
  logic [1:0]      off_q;

  logic [1:0]  al_size;
  logic [1:0]  al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;

  // In IDLE the aligner sees the live request; afterwards the latched one for load extraction.
  assign al_size = (state_q == StIdle) ? whb       : whb_q;
  assign al_off  = (state_q == StIdle) ? addr[1:0] : off_q;

  lsu_lane_align u_align (
    .size_i      (al_size),
    .offset_i    (al_off),
    .wdata_i     (wdata),
    .mem_rdata_i (mem_rdata),
    .su_i        (su_q),
    .be_o        (al_be),
    .wdata_rep_o (al_wdata),
    .load_data_o (al_load)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rw_q      <= 1'b0;
      su_q      <= 1'b0;
      whb_q     <= 2'b00;
      off_q     <= 2'b00;
      rdata     <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            rw_q  <= rw;
            su_q  <= su;
            whb_q <= whb;
            off_q <= addr[1:0];
            rdata <= '0;
            busy  <= 1'b1;
            if (lsu_misaligned(whb, addr[1:0])) begin
              state_q <= StDone;
              done    <= 1'b1;
              err     <= 1'b1;
            end else begin
              state_q   <= StReq;
              cnt_q     <= '0;
              mem_req   <= 1'b1;
              mem_we    <= (rw == RW_STORE);
              mem_be    <= al_be;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= al_wdata;
            end
          end
        end
        StReq: begin
          // Ack is checked first so an ack on the expiry cycle completes cleanly.
          if (mem_ack) begin
            state_q <= StDone;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            if (rw_q == RW_LOAD) begin
              rdata <= al_load;
            end
          end else if (cnt_q == CntLast) begin
            state_q <= StDone;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            err     <= 1'b1;
            rdata   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Self-checking bench for lsu_mem_if: directed test-plan cases plus randomized traffic.
module tb_lsu_mem_if;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rw;
  logic [1:0]  whb;
  logic        su;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsu_mem_if #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rw        (rw),
    .whb       (whb),
    .su        (su),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  // Reference model: access width in bytes, 0 for the illegal encoding.
  function automatic int size_bytes(logic [1:0] w);
    case (w)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] model_be(int s, logic [1:0] off);
    int v;
    v = ((1 << s) - 1) << off;
    return v[3:0];
  endfunction

  function automatic logic [31:0] model_wrep(int s, logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = d[8*(k % s) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(int s, logic [1:0] off, logic sgn, logic [31:0] d);
    longint v;
    v = longint'(d) >> (8 * off);
    v = v & ((64'd1 << (8 * s)) - 1);
    if (sgn && v[8*s-1]) v = v - (64'd1 << (8 * s));
    return v[31:0];
  endfunction

  task automatic idle_inputs();
    start = 1'b0; rw = 1'b0; whb = 2'b00; su = 1'b0;
    addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
  endtask

  // One transaction. ack_delay = REQ cycles before ack; >= TO means no ack.
  task automatic do_op(input string name, input logic op_rw, input logic [1:0] op_whb,
                       input logic op_su, input logic [31:0] op_addr, input logic [31:0] op_wd,
                       input logic [31:0] op_mrd, input int ack_delay, input bit hold_start);
    int s;
    bit bad;
    bit acked;
    logic [71:0] obs, expv;
    logic [35:0] obs_d, exp_d;
    logic [2:0]  obs_t;
    s     = size_bytes(op_whb);
    bad   = (s == 0) ? 1'b1 : ((int'(op_addr[1:0]) % s) != 0);
    acked = 1'b0;
    start = 1'b1; rw = op_rw; whb = op_whb; su = op_su; addr = op_addr; wdata = op_wd;
    @(posedge clk); #1;
    // Scramble request inputs: the DUT must work from what it latched.
    start = hold_start; rw = 1'($urandom); whb = 2'($urandom); su = 1'($urandom);
    addr = $urandom; wdata = $urandom;
    if (bad) begin
      n_cmp++;
      if ({done, err, mem_req, busy} !== 4'b1101) begin
        n_bad++;
        $display("FAIL %s misaligned: {done,err,req,busy} got %b want 1101", name,
                 {done, err, mem_req, busy});
      end
    end else begin
      for (int cyc = 0; cyc < int'(TO); cyc++) begin
        expv = {1'b1, ~op_rw, model_be(s, op_addr[1:0]), op_addr & 32'hFFFF_FFFC,
                model_wrep(s, op_wd), 1'b0, 1'b1};
        obs  = {mem_req, mem_we, mem_be, mem_addr, mem_wdata, done, busy};
        n_cmp++;
        if (obs !== expv) begin
          n_bad++;
          $display("FAIL %s req cyc %0d: {req,we,be,addr,wd,done,busy} got %h want %h",
                   name, cyc, obs, expv);
        end
        mem_rdata = $urandom;
        if (cyc == ack_delay) begin
          mem_ack = 1'b1; mem_rdata = op_mrd; acked = 1'b1;
        end
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = $urandom;
        if (acked) break;
      end
      exp_d = {1'b1, ~acked, 1'b0, 1'b1,
               (acked && op_rw) ? model_load(s, op_addr[1:0], op_su, op_mrd) : 32'h0};
      obs_d = {done, err, mem_req, busy, rdata};
      n_cmp++;
      if (obs_d !== exp_d) begin
        n_bad++;
        $display("FAIL %s completion: {done,err,req,busy,rdata} got %h want %h",
                 name, obs_d, exp_d);
      end
    end
    // Stray acks outside REQ must be ignored; a held start must not be queued.
    mem_ack = 1'($urandom);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      start = 1'b0; mem_ack = (i == 0) ? 1'($urandom) : 1'b0;
      obs_t = {done, busy, mem_req};
      n_cmp++;
      if (obs_t !== 3'b000) begin
        n_bad++;
        $display("FAIL %s idle %0d: {done,busy,req} got %b want 000", name, i, obs_t);
      end
    end
  endtask

  task automatic test_reset();
    logic [109:0] obs;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    obs = {rdata, done, err, busy, mem_req, mem_we, mem_be, mem_addr, mem_wdata};
    n_cmp++;
    if (obs !== '0) begin
      n_bad++;
      $display("FAIL reset state: got %h want 0", obs);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_op("sw",  1'b0, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, 32'h0,        0, 1'b0);
    do_op("lb",  1'b1, 2'b00, 1'b1, 32'h203, 32'h0,        32'h80112233, 0, 1'b0);
    do_op("lbu", 1'b1, 2'b00, 1'b0, 32'h203, 32'h0,        32'h80112233, 1, 1'b0);
    do_op("sh",  1'b0, 2'b01, 1'b0, 32'h12,  32'h0000A5A5, 32'h0,        2, 1'b0);
    do_op("lh",  1'b1, 2'b01, 1'b1, 32'h12,  32'h0,        32'h7FFF0000, 0, 1'b0);
  endtask

  task automatic test_misaligned();
    do_op("lw_mis",  1'b1, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 0, 1'b0);
    do_op("illegal", 1'b1, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 0, 1'b0);
    do_op("sh_mis",  1'b0, 2'b01, 1'b0, 32'h21,  32'h5, 32'h0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    do_op("timeout",   1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 32'h12345678, 99,          1'b0);
    do_op("ack_expiry", 1'b1, 2'b10, 1'b0, 32'h44, 32'h0, 32'h12345678, int'(TO) - 1, 1'b0);
  endtask

  task automatic test_busy_start();
    do_op("held_start", 1'b1, 2'b01, 1'b1, 32'h32, 32'h0, 32'hC0DE8001, 2, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [2:0] obs;
    start = 1'b1; rw = 1'b0; whb = 2'b10; su = 1'b0; addr = 32'h80; wdata = 32'h11;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    obs = {mem_req, busy, done};
    n_cmp++;
    if (obs !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_mid: {req,busy,done} got %b want 000", obs);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({done, busy} !== 2'b00) begin
        n_bad++;
        $display("FAIL reset_mid after %0d: {done,busy} got %b want 00", i, {done, busy});
      end
    end
  endtask

  task automatic test_random();
    logic        r_rw;
    logic [1:0]  r_whb;
    logic [31:0] r_addr;
    int          s;
    for (int n = 0; n < 40; n++) begin
      r_rw   = 1'($urandom);
      r_whb  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r_addr = $urandom;
      s      = size_bytes(r_whb);
      if (s != 0 && $urandom_range(0, 3) != 0) r_addr = r_addr & ~(32'(s) - 32'd1);
      do_op("random", r_rw, r_whb, 1'($urandom), r_addr, $urandom, $urandom,
            $urandom_range(0, TO + 1), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misaligned();
    test_timeout();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_if.md
# lsu_mem_if

Load/store memory interface for the unpipelined RISC-V core. It sits directly downstream of the instruction decoder and consumes its `rw`, `whb` and `su` outputs, together with the ALU-computed address and the rs2 store data. It runs a request/acknowledge transaction against the data memory, generating byte enables and lane-replicated store data, and returns the aligned, sign- or zero-extended load result. `busy` stalls the PC while a transaction is in flight.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum cycles in REQ waiting for `mem_ack` before an error completion.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  memory op valid; sampled only in IDLE.
- `rw`  in  1  1 = load, 0 = store.
- `whb`  in  2  access size: 10 = word, 01 = half, 00 = byte, 11 = illegal.
- `su`  in  1  load extension: 1 = signed, 0 = unsigned.
- `addr`  in  32  byte address.
- `wdata`  in  32  store data (rs2).
- `rdata`  out  32  load result; valid while `done` = 1.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`: misaligned, illegal or timeout.
- `busy`  out  1  high when state != IDLE.
- `mem_req`  out  1  memory request, held until ack.
- `mem_we`  out  1  1 = write.
- `mem_be`  out  4  byte enables.
- `mem_addr`  out  32  word address, `{addr[31:2],2'b00}`.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  memory completion; read data valid the same cycle.
- `mem_rdata`  in  32  memory read word.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE with `start` = 1: latch `rw`, `whb`, `su`, `addr`, `wdata`.
  - If the access is misaligned (half with `addr[0]` = 1, word with `addr[1:0]` != 0) or `whb` = 11: go to DONE with `err` = 1. No `mem_req` is issued.
  - Otherwise go to REQ.
- REQ: `mem_req` = 1, and `mem_we` = !`rw`. The wait counter increments each cycle.
  - On `mem_ack`, go to DONE. For a load, the extracted data is registered into `rdata`.
  - If the counter reaches `TIMEOUT` - 1 without an ack, go to DONE with `err` = 1 and `rdata` = 0.
- DONE: `done` = 1 for exactly one cycle, then return to IDLE.
- Byte enables:
  - byte: 0001 shifted left by `addr[1:0]`.
  - half: 0011 if `addr[1]` = 0, else 1100.
  - word: 1111.
- Store data: byte = `{4{wdata[7:0]}}`, half = `{2{wdata[15:0]}}`, word = `wdata`.
- Load extraction: shift `mem_rdata` right by 8·`addr[1:0]`, take the low 8/16/32 bits, then sign-extend if `su` = 1, else zero-extend.
- Stores leave `rdata` = 0.
- Boundary cases:
  - `start` while busy: ignored, not queued.
  - `mem_ack` outside REQ: ignored.
  - `mem_ack` in the same cycle as timeout expiry: the ack wins and `err` = 0.

## Timing
- Reset values: state IDLE, `rdata` = 0, and `done`, `err`, `busy`, `mem_req`, `mem_we` = 0; `mem_be` = 0, `mem_addr` = 0, `mem_wdata` = 0, counter = 0.
- Reset mid-transaction: `mem_req` drops on the next edge; no `done` is produced.
- Memory outputs are registered and stable for the whole of REQ.
- Latency with ack in the first REQ cycle: `start` at edge N → `mem_req` high N+1 → `done` high N+2. Each extra wait cycle adds one.
- Misaligned access: `done` with `err` = 1 at N+1.
- Timeout: `done` at N+1+`TIMEOUT`.
- `busy` is high from N+1 through the DONE cycle.

## Structure
- Shared package `riscv_lsu_pkg`:
  - `whb` encodings (`WHB_WORD`, `WHB_HALF`, `WHB_BYTE`).
  - FSM state typedef.
  - `rw` encodings.
  - Default `TIMEOUT`.
- Sub-module `lsu_lane_align` (combinational): takes size, `addr[1:0]`, `wdata`, `mem_rdata` and `su`; produces `mem_be`, replicated store data and the extended load data. The FSM and counter stay in `lsu_mem_if`.

## Test plan
- SW `addr` = 0x104, `wdata` = 0xDEADBEEF, ack after 1 cycle → `mem_addr` = 0x104, `mem_be` = 1111, `mem_wdata` = 0xDEADBEEF, `done` at N+2, `err` = 0.
- LB signed, `addr` = 0x203, `mem_rdata` = 0x80112233 → `mem_be` = 1000, `rdata` = 0xFFFFFF80. Same access as LBU → 0x00000080.
- SH `addr` = 0x12, `wdata` = 0x0000A5A5 → `mem_be` = 1100, `mem_wdata` = 0xA5A5A5A5. LH at `addr` = 0x12 with `mem_rdata` = 0x7FFF0000 → `rdata` = 0x00007FFF.
- LW `addr` = 0x102 → no `mem_req`, `done` with `err` = 1 at N+1. `whb` = 11 gives the same result.
- `mem_ack` never arrives with `TIMEOUT` = 4 → `done` with `err` = 1 at N+5 and `rdata` = 0. Repeat with ack on the expiry cycle → `err` = 0.
- `rst` asserted during REQ → `mem_req` = 0 and `busy` = 0 at the next edge, no `done`. `start` pulsed while busy → ignored.
